// File: rtl/uart_tx_arb.sv
// Four-requester round-robin arbiter feeding a single UART transmitter.
// Grants one byte per frame, strobes tx_wrsig, and tracks the transmitter busy line.
module uart_tx_arb #(
  parameter int WR_HOLD   = 2,
  parameter int START_TMO = 8,
  parameter int GAP       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  input  logic [7:0] din2,
  input  logic [7:0] din3,
  output logic [3:0] ack,
  output logic [7:0] tx_data,
  output logic       tx_wrsig,
  input  logic       tx_busy,
  output logic       done,
  output logic [1:0] done_id,
  output logic       err,
  output logic       active
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAPW} state_t;

  localparam logic [7:0] WR_LAST  = 8'(WR_HOLD - 1);
  localparam logic [7:0] TMO_LAST = 8'(START_TMO - 1);
  localparam logic [7:0] GAP_CNT  = 8'(GAP);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic [3:0] ack_q, ack_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_wrsig_q, tx_wrsig_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] done_id_q, done_id_d;
  logic       active_q, active_d;

  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [7:0] din_sel;

  // Search last+1, last+2, last+3, last so the previous winner ranks lowest.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!grant_vld && req[last_q + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = last_q + 2'(k);
      end
    end
  end

  always_comb begin
    unique case (grant_idx)
      2'd0:    din_sel = din0;
      2'd1:    din_sel = din1;
      2'd2:    din_sel = din2;
      default: din_sel = din3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    done_id_d  = done_id_q;
    ack_d      = '0;
    tx_wrsig_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A busy line here is a frame we did not launch; never overlap it.
        if (grant_vld && !tx_busy) begin
          state_d    = LOAD;
          ack_d      = 4'b0001 << grant_idx;
          last_d     = grant_idx;
          tx_data_d  = din_sel;
          tx_wrsig_d = 1'b1;
          cnt_d      = '0;
        end
      end
      LOAD: begin
        if (cnt_q == WR_LAST) begin
          state_d = WAIT_BUSY;
          cnt_d   = '0;
        end else begin
          tx_wrsig_d = 1'b1;
          cnt_d      = cnt_q + 8'd1;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = GAPW;
          err_d     = 1'b1;
          done_id_d = last_q;
          cnt_d     = '0;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d   = GAPW;
          done_d    = 1'b1;
          done_id_d = last_q;
          cnt_d     = '0;
        end
      end
      GAPW: begin
        // The done/err cycle is the first GAPW cycle; GAP more follow it.
        if (cnt_q == GAP_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      ack_q      <= '0;
      tx_data_q  <= '0;
      tx_wrsig_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      done_id_q  <= '0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_wrsig_q <= tx_wrsig_d;
      done_q     <= done_d;
      err_q      <= err_d;
      done_id_q  <= done_id_d;
      active_q   <= active_d;
    end
  end

  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign tx_wrsig = tx_wrsig_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign err      = err_q;
  assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: randomized frames against a round-robin
// reference model, plus directed reset, timeout, busy-block and gap scenarios.
module tb_uart_tx_arb;
  localparam int WR_HOLD   = 2;
  localparam int START_TMO = 8;
  localparam int GAP_B     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0, req_g = '0;
  logic [7:0] din [4];
  logic [3:0] ack, ack_g;
  logic [7:0] tx_data, tx_data_g;
  logic       tx_wrsig, tx_wrsig_g, tx_busy, tx_busy_g;
  logic       done, done_g, err, err_g, active, active_g;
  logic [1:0] done_id, done_id_g;

  int n_chk = 0, n_fail = 0, cyc = 0, m_last = 0;

  uart_tx_arb #(.WR_HOLD(WR_HOLD), .START_TMO(START_TMO), .GAP(0)) dut (
    .clk(clk), .rst(rst), .req(req),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .ack(ack), .tx_data(tx_data), .tx_wrsig(tx_wrsig), .tx_busy(tx_busy),
    .done(done), .done_id(done_id), .err(err), .active(active));

  uart_tx_arb #(.WR_HOLD(WR_HOLD), .START_TMO(START_TMO), .GAP(GAP_B)) dut_g (
    .clk(clk), .rst(rst), .req(req_g),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .ack(ack_g), .tx_data(tx_data_g), .tx_wrsig(tx_wrsig_g), .tx_busy(tx_busy_g),
    .done(done_g), .done_id(done_id_g), .err(err_g), .active(active_g));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter models: start on the rising edge of the strobe, busy after a delay.
  bit   tx_dead = 1'b0, force_busy = 1'b0;
  logic wr_prev = 1'b0, wr_prev_g = 1'b0;
  int   tx_t = 0, tx_dly = 1, tx_len = 3, tx_tg = 0;

  always @(posedge clk) begin
    wr_prev <= tx_wrsig;
    if (tx_wrsig && !wr_prev && !tx_dead) begin
      tx_t   <= 1;
      tx_dly <= $urandom_range(3, 1);
      tx_len <= $urandom_range(6, 3);
    end else if (tx_t != 0 && tx_t < tx_dly + tx_len) tx_t <= tx_t + 1;
    else tx_t <= 0;
  end
  assign tx_busy = force_busy || (tx_t > tx_dly);

  always @(posedge clk) begin
    wr_prev_g <= tx_wrsig_g;
    if (tx_wrsig_g && !wr_prev_g) tx_tg <= 1;
    else if (tx_tg != 0 && tx_tg < 4) tx_tg <= tx_tg + 1;
    else tx_tg <= 0;
  end
  assign tx_busy_g = (tx_tg > 1);

  function automatic int next_grant(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follows one frame on the GAP=0 instance from grant to done/err.
  task automatic serve_frame(input int exp_idx, input bit exp_err,
                             output int wait_n, output int ack_c, output int end_c);
    int n, bad;
    bit saw, fin;
    logic [7:0] dat;
    logic [3:0] exp_ack;
    exp_ack = 4'(1 << exp_idx);
    wait_n = 0; ack_c = cyc; end_c = cyc;
    do begin tick(); wait_n++; end while (ack == 4'b0 && wait_n < 60);
    n_chk++;
    if (ack !== exp_ack) begin
      n_fail++; $display("FAIL grant_ack: got %b want %b", ack, exp_ack);
    end
    if (ack == 4'b0) return;
    ack_c = cyc;
    n_chk++;
    if (tx_data !== din[exp_idx] || tx_wrsig !== 1'b1 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL grant_cycle: data %h wr %b act %b want %h 1 1", tx_data, tx_wrsig, active, din[exp_idx]);
    end
    dat = tx_data; bad = 0; n = 1;
    tick();
    while (tx_wrsig && n < 40) begin
      if (ack != 0 || tx_data !== dat) bad++;
      n++; tick();
    end
    n_chk++;
    if (n != WR_HOLD) begin n_fail++; $display("FAIL wrsig_len: got %0d want %0d", n, WR_HOLD); end
    fin = 1'b0; saw = 1'b0; n = 0;
    while (!fin && n < 100) begin
      if (ack != 0 || tx_data !== dat || tx_wrsig || done) bad++;
      if (exp_err) fin = err;
      else begin
        if (err) bad++;
        if (tx_busy) saw = 1'b1;
        else if (saw) fin = 1'b1;
      end
      if (!fin || !exp_err) begin tick(); n++; end
    end
    end_c = cyc;
    if (exp_err) begin
      n_chk++;
      if (!err || n != START_TMO || done_id !== 2'(exp_idx)) begin
        n_fail++;
        $display("FAIL timeout: err %b after %0d cycles id %0d want 1 %0d %0d", err, n, done_id, START_TMO, exp_idx);
      end
    end else begin
      n_chk++;
      if (done !== 1'b1 || err !== 1'b0 || done_id !== 2'(exp_idx)) begin
        n_fail++;
        $display("FAIL done_pulse: done %b err %b id %0d want 1 0 %0d", done, err, done_id, exp_idx);
      end
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL frame_invariants: %0d violations want 0", bad); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    repeat (3) tick();
    n_chk++;
    if ({ack, tx_wrsig, done, err, active, tx_data, done_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack %b wr %b done %b err %b act %b data %h id %0d want all 0",
               ack, tx_wrsig, done, err, active, tx_data, done_id);
    end
    rst = 1'b0; m_last = 0;
  endtask

  task automatic test_single();
    int w, a, e;
    din[0] = 8'hA5;
    req = 4'b0001;
    serve_frame(0, 1'b0, w, a, e);
    n_chk++;
    if (w != 1) begin n_fail++; $display("FAIL first_ack_latency: got %0d want 1", w); end
    req = '0; m_last = 0;
  endtask

  task automatic test_round_robin();
    int w, a, e, prev_e, exp;
    int order [5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
    req = 4'b1111; prev_e = -1;
    for (int f = 0; f < 5; f++) begin
      exp = next_grant(req, m_last);
      n_chk++;
      if (exp != order[f]) begin n_fail++; $display("FAIL rr_model_order: got %0d want %0d", exp, order[f]); end
      serve_frame(exp, 1'b0, w, a, e);
      if (prev_e >= 0) begin
        n_chk++;
        if (a - prev_e != 2) begin n_fail++; $display("FAIL rr_ack_after_done: gap %0d want 2", a - prev_e); end
      end
      prev_e = e; m_last = exp;
    end
    req = '0;
  endtask

  task automatic test_timeout();
    int w, a, e, exp;
    tx_dead = 1'b1;
    req = 4'($urandom_range(15, 1));
    exp = next_grant(req, m_last);
    serve_frame(exp, 1'b1, w, a, e);
    req = '0; m_last = exp; tx_dead = 1'b0;
    req = 4'($urandom_range(15, 1));
    exp = next_grant(req, m_last);
    serve_frame(exp, 1'b0, w, a, e);
    req = '0; m_last = exp;
  endtask

  task automatic test_busy_block();
    int w, a, e, bad;
    bad = 0;
    force_busy = 1'b1; req = 4'b0100;
    repeat (8) begin tick(); if (ack != 0 || active) bad++; end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL busy_blocks_grant: %0d grant cycles want 0", bad); end
    force_busy = 1'b0;
    serve_frame(2, 1'b0, w, a, e);
    n_chk++;
    if (w != 1) begin n_fail++; $display("FAIL ack_after_busy_falls: got %0d cycles want 1", w); end
    req = '0; m_last = 2;
  endtask

  task automatic test_mid_reset();
    int n, bad, w, a, e, exp;
    req = 4'b0100; n = 0;
    do begin tick(); n++; end while (ack == 4'b0 && n < 40);
    req = '0; n = 0;
    do begin tick(); n++; end while (!(tx_busy && !tx_wrsig) && n < 40);
    tick();
    rst = 1'b1;
    tick();
    n_chk++;
    if ({ack, tx_wrsig, done, err, active, tx_data, done_id} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: ack %b wr %b done %b err %b act %b data %h id %0d want all 0",
               ack, tx_wrsig, done, err, active, tx_data, done_id);
    end
    rst = 1'b0; bad = 0;
    repeat (12) begin tick(); if (done || err || ack != 0 || active) bad++; end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL post_reset_quiet: %0d pulses want 0", bad); end
    req = 4'b1011;
    exp = next_grant(req, 0);
    serve_frame(exp, 1'b0, w, a, e);
    req = '0; m_last = exp;
  endtask

  task automatic test_random();
    int w, a, e, exp;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) din[j] = 8'($urandom);
      req = 4'($urandom_range(15, 1));
      exp = next_grant(req, m_last);
      serve_frame(exp, 1'b0, w, a, e);
      req = '0; m_last = exp;
    end
  endtask

  task automatic test_gap();
    int n, dc, bad;
    logic [7:0] dat;
    for (int j = 0; j < 4; j++) din[j] = 8'($urandom);
    req_g = 4'b0011; n = 0;
    do begin tick(); n++; end while (ack_g == 4'b0 && n < 50);
    n_chk++;
    if (ack_g !== 4'b0010 || tx_data_g !== din[1]) begin
      n_fail++; $display("FAIL gap_first_grant: ack %b data %h want 0010 %h", ack_g, tx_data_g, din[1]);
    end
    req_g[1] = 1'b0; dat = tx_data_g; n = 0;
    do begin tick(); n++; end while (!done_g && n < 100);
    n_chk++;
    if (done_g !== 1'b1 || done_id_g !== 2'd1) begin
      n_fail++; $display("FAIL gap_done: done %b id %0d want 1 1", done_g, done_id_g);
    end
    dc = cyc; bad = 0; n = 0;
    do begin if (tx_data_g !== dat) bad++; tick(); n++; end while (ack_g == 4'b0 && n < 50);
    n_chk++;
    if (ack_g !== 4'b0001 || cyc - dc != GAP_B + 2) begin
      n_fail++; $display("FAIL gap_spacing: ack %b after %0d cycles want 0001 after %0d", ack_g, cyc - dc, GAP_B + 2);
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL gap_data_stable: %0d changes want 0", bad); end
    req_g = '0;
  endtask

  initial begin
    for (int j = 0; j < 4; j++) din[j] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_busy_block();
    test_mid_reset();
    test_random();
    test_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter WR_HOLD, default 2: number of cycles tx_wrsig is held high per launch; legal range 1..15.
REQ-002 Parameter START_TMO, default 8: number of cycles allowed for tx_busy to rise after tx_wrsig falls; legal range 1..255.
REQ-003 Parameter GAP, default 0: number of idle cycles inserted after each frame before the next arbitration; legal range 0..255.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  4  per-requester request; level-held until acked.
REQ-007 din0..din3  in  8 each  per-requester byte; stable while the matching req is high.
REQ-008 ack  out  4  one-hot, single-cycle pulse; the byte of that requester is accepted.
REQ-009 tx_data  out  8  byte to the transmitter; stable for the entire frame.
REQ-010 tx_wrsig  out  1  launch strobe to the transmitter; the transmitter starts on its rising edge.
REQ-011 tx_busy  in  1  transmitter line status; high = frame in progress.
REQ-012 done  out  1  single-cycle pulse when a frame completes.
REQ-013 done_id  out  2  requester index for done/err; valid only while done or err is high.
REQ-014 err  out  1  single-cycle pulse when a start timeout occurs.
REQ-015 active  out  1  high in every state other than IDLE.

Function
REQ-016 The block SHALL implement the FSM states IDLE, LOAD, WAIT_BUSY, WAIT_DONE and GAPW.
REQ-017 IDLE, req==0: the block SHALL remain in IDLE.
REQ-018 IDLE, req!=0: the block SHALL grant round-robin, searching from (last+1) mod 4 upward, latch tx_data from the granted din, set last to the granted index, pulse ack for that index in the same cycle, and go to LOAD.
REQ-019 Only one ack bit SHALL be high at any time, and ack SHALL be asserted only on the IDLE->LOAD transition.
REQ-020 LOAD: tx_wrsig SHALL be 1 for exactly WR_HOLD cycles, starting the cycle after the grant, then 0, and the block SHALL go to WAIT_BUSY.
REQ-021 WAIT_BUSY, tx_busy==1 within START_TMO cycles: the block SHALL go to WAIT_DONE.
REQ-022 WAIT_BUSY, timeout: the block SHALL pulse err with done_id=last and go to GAPW.
REQ-023 Timeout counting SHALL be saturating and SHALL use an 8-bit counter.
REQ-024 WAIT_DONE, tx_busy==0: the block SHALL pulse done with done_id=last and go to GAPW.
REQ-025 WAIT_DONE SHALL have no timeout.
REQ-026 GAPW: the block SHALL wait GAP cycles, then return to IDLE; with GAP=0 it SHALL return to IDLE on the next cycle.
REQ-027 tx_data SHALL change only on the IDLE->LOAD transition.
REQ-028 tx_wrsig SHALL be 0 in every state other than LOAD.
REQ-029 A req that deasserts after being granted SHALL have no effect on the frame in progress.
REQ-030 A req that deasserts before being granted SHALL be dropped with no ack.
REQ-031 A new request arriving during a frame SHALL be held off, with no ack, until the block is back in IDLE.
REQ-032 tx_busy high while in IDLE (a foreign or leftover frame) SHALL block granting until tx_busy is 0.
REQ-033 Simultaneous requests: exactly one requester SHALL be granted per frame, and with 4 requesters continuously active no requester SHALL wait more than 3 frames.
REQ-034 A full 4-requester round SHALL produce the grant order last+1, last+2, last+3, last, wrapping mod 4.

Reset
REQ-035 rst high SHALL return the FSM to IDLE.
REQ-036 rst high SHALL clear ack, tx_wrsig, done, err, active, tx_data, done_id, last and all counters to 0.
REQ-037 A consequence of last=0 after reset SHALL be that the first grant searches starting from index 1.
REQ-038 rst asserted mid-frame SHALL abort immediately, with no done and no err.
REQ-039 The first grant after reset SHALL occur no earlier than the second cycle after rst deasserts, and only once tx_busy is 0.

Verification
REQ-040 Scenario 1: after reset, req=0001, din0=0xA5 -> ack=0001 next cycle; tx_data=0xA5; tx_wrsig high 2 cycles; transmitter model raises busy; done pulse with done_id=0 one cycle after busy falls.
REQ-041 Scenario 2: req=1111 held with GAP=0 -> grant order 1,2,3,0,1 (last=0 after reset); each ack occurs only after the previous done; tx_data always equals the granted din.
REQ-042 Scenario 3: transmitter model never raises busy, START_TMO=8 -> err pulse with done_id equal to the granted index 8 cycles after tx_wrsig falls; the next request is then served normally.
REQ-043 Scenario 4: rst asserted during WAIT_DONE -> the next cycle has all outputs 0 and the FSM in IDLE; no done pulse; next grant starts the search from index 1.
REQ-044 Scenario 5: tx_busy held high while in IDLE with req=0100 -> no ack until tx_busy falls, then ack=0100 in the following cycle.
REQ-045 Scenario 6: GAP=3 with two back-to-back requesters -> exactly 3 cycles in GAPW between done and the next ack; tx_data unchanged across GAPW.
